// File: rtl/tvm_buffer_wr_arbiter_pkg.sv
// Shared definitions for the tvm_buffer write-side arbiter.
// The state encoding is shared with future buffer read-side sequencers.
package tvm_buffer_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        ADVANCE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/tvm_rr_arbiter.sv
// Combinational rotate-priority pick.
// Scans from last_grant+1 upward, modulo NUM_REQ.
module tvm_rr_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int REQ_IDX_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]       req,
    input  logic [REQ_IDX_WIDTH-1:0] last_grant,
    output logic                     any,
    output logic [REQ_IDX_WIDTH-1:0] idx
);

    logic [REQ_IDX_WIDTH-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = REQ_IDX_WIDTH'((int'(last_grant) + off) % NUM_REQ);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tvm_buffer_wr_arbiter.sv
// Shares one tvm_buffer write port among NUM_REQ producers, one full window per grant,
// with a one-cycle write_advance commit and round-robin re-arbitration between windows.
module tvm_buffer_wr_arbiter
    import tvm_buffer_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int REQ_IDX_WIDTH = 1,
    parameter int DATA_WIDTH    = 8,
    parameter int WR_WINDOW     = 16,
    parameter int WR_ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write_valid,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [WR_ADDR_WIDTH-1:0]      write_addr,
    input  logic                          write_ready,
    output logic                          write_advance,
    output logic [REQ_IDX_WIDTH-1:0]      grant_idx,
    output logic                          busy
);

    wr_state_t                state;
    logic [WR_ADDR_WIDTH-1:0] word_cnt;
    logic [REQ_IDX_WIDTH-1:0] owner;
    logic [REQ_IDX_WIDTH-1:0] last_grant;
    logic [REQ_IDX_WIDTH-1:0] pick_idx;
    logic                     pick_any;
    logic                     handshake;
    logic                     last_word;

    tvm_rr_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    // Only the owner sees the buffer's ready; everyone else is held off.
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[owner] = write_ready;
        end
    end

    assign write_valid   = (state == BURST) & req_valid[owner];
    assign write_data    = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign write_addr    = word_cnt;
    assign write_advance = (state == ADVANCE);
    assign grant_idx     = owner;
    assign busy          = (state != IDLE);
    assign handshake     = write_valid & write_ready;
    assign last_word     = (word_cnt == WR_ADDR_WIDTH'(WR_WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_cnt   <= '0;
            owner      <= '0;
            last_grant <= REQ_IDX_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // No partial windows: the window only closes on its last accepted word.
                    if (handshake) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            state    <= ADVANCE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tvm_buffer_wr_arbiter.sv
// Directed bench for tvm_buffer_wr_arbiter: a 2-producer instance for most scenarios
// and a 3-producer instance for round-robin rotation; the buffer side is a ready model.
module tb_tvm_buffer_wr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        write_valid;
    logic [7:0]  write_data;
    logic [4:0]  write_addr;
    logic        write_ready;
    logic        write_advance;
    logic [0:0]  grant_idx;
    logic        busy;

    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_ready3;
    logic        write_valid3;
    logic [7:0]  write_data3;
    logic [4:0]  write_addr3;
    logic        write_ready3;
    logic        write_advance3;
    logic [1:0]  grant_idx3;
    logic        busy3;

    logic [3:0] seq  [0:1];
    logic [3:0] seq3 [0:2];
    int vectors     = 0;
    int miscompares = 0;
    int wcount      = 0;
    int adv_count   = 0;

    tvm_buffer_wr_arbiter #(
        .NUM_REQ(2), .REQ_IDX_WIDTH(1), .DATA_WIDTH(8), .WR_WINDOW(16), .WR_ADDR_WIDTH(5)
    ) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .write_valid(write_valid), .write_data(write_data), .write_addr(write_addr),
        .write_ready(write_ready), .write_advance(write_advance), .grant_idx(grant_idx), .busy(busy)
    );

    tvm_buffer_wr_arbiter #(
        .NUM_REQ(3), .REQ_IDX_WIDTH(2), .DATA_WIDTH(8), .WR_WINDOW(16), .WR_ADDR_WIDTH(5)
    ) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3), .req_ready(req_ready3),
        .write_valid(write_valid3), .write_data(write_data3), .write_addr(write_addr3),
        .write_ready(write_ready3), .write_advance(write_advance3), .grant_idx(grant_idx3),
        .busy(busy3)
    );

    // Producer i sends {i+1, sequence number}; the sequence steps on each accepted word.
    assign req_data  = {4'd2, seq[1], 4'd1, seq[0]};
    assign req_data3 = {4'd3, seq3[2], 4'd2, seq3[1], 4'd1, seq3[0]};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) seq[i] <= '0;
            for (int i = 0; i < 3; i++) seq3[i] <= '0;
            wcount <= 0;
        end else begin
            for (int i = 0; i < 2; i++) if (req_valid[i] & req_ready[i]) seq[i] <= seq[i] + 4'd1;
            for (int i = 0; i < 3; i++) if (req_valid3[i] & req_ready3[i]) seq3[i] <= seq3[i] + 4'd1;
            if (write_valid & write_ready) wcount <= wcount + 1;
        end
    end

    always @(posedge clk) if (write_advance) adv_count <= adv_count + 1;

    function automatic logic [18:0] pk2(logic wv, logic [4:0] a, logic [7:0] d, logic [1:0] rr,
                                        logic adv, logic g, logic b);
        return {wv, a, (wv ? d : 8'h00), rr, adv, g, b};
    endfunction

    function automatic logic [20:0] pk3(logic wv, logic [4:0] a, logic [7:0] d, logic [2:0] rr,
                                        logic adv, logic [1:0] g, logic b);
        return {wv, a, (wv ? d : 8'h00), rr, adv, g, b};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_valid3 = '0; write_ready = 1'b0; write_ready3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        logic [20:0] obs3;
        rst = 1'b1;
        req_valid = 2'b11; req_valid3 = 3'b111; write_ready = 1'b1; write_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL reset2 got %h want %h", obs, 19'd0);
        end
        obs3 = pk3(write_valid3, write_addr3, write_data3, req_ready3, write_advance3, grant_idx3, busy3);
        vectors++;
        if (obs3 !== 21'd0) begin
            miscompares++;
            $display("FAIL reset3 got %h want %h", obs3, 21'd0);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_single();
        logic [18:0] obs, exp;
        do_reset();
        req_valid = 2'b01; write_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0 || k == 18)      exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, 1'b0, 0);
            else if (k == 17)           exp = pk2(0, 5'd0, 8'h00, 2'b00, 1, 1'b0, 1);
            else if (k == 19)           exp = pk2(1, 5'd0, 8'h10, 2'b01, 0, 1'b0, 1);
            else                        exp = pk2(1, 5'(k-1), {4'd1, 4'(k-1)}, 2'b01, 0, 1'b0, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 17) begin
                vectors++;
                if (wcount !== 16) begin
                    miscompares++;
                    $display("FAIL single_count got %0d want 16", wcount);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] obs, exp;
        int w, p;
        logic o, g;
        do_reset();
        req_valid = 2'b11; write_ready = 1'b1;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            w = k / 18; p = k % 18;
            o = 1'(w % 2);
            g = (w == 0) ? 1'b0 : 1'((w - 1) % 2);
            if (p == 0)       exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, g, 0);
            else if (p == 17) exp = pk2(0, 5'd0, 8'h00, 2'b00, 1, o, 1);
            else              exp = pk2(1, 5'(p-1), {4'(o+1), 4'(p-1)}, (o ? 2'b10 : 2'b01), 0, o, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d got %h want %h", k, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_owner_drop();
        logic [18:0] obs, exp;
        int adv0;
        do_reset();
        adv0 = adv_count;
        req_valid = 2'b01; write_ready = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 0 || k == 21)   exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, 1'b0, 0);
            else if (k <= 5)         exp = pk2(1, 5'(k-1), {4'd1, 4'(k-1)}, 2'b01, 0, 1'b0, 1);
            else if (k <= 8)         exp = pk2(0, 5'd5, 8'h00, 2'b01, 0, 1'b0, 1);
            else if (k <= 19)        exp = pk2(1, 5'(k-4), {4'd1, 4'(k-4)}, 2'b01, 0, 1'b0, 1);
            else                     exp = pk2(0, 5'd0, 8'h00, 2'b00, 1, 1'b0, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL owner_drop k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 20) begin
                vectors++;
                if (wcount !== 16 || adv_count !== adv0) begin
                    miscompares++;
                    $display("FAIL owner_drop_count got %0d/%0d want 16/%0d", wcount, adv_count, adv0);
                end
            end
            @(posedge clk); #1;
            // Owner goes quiet while the other producer asks; neither may steal the window.
            if (k == 5) req_valid = 2'b10;
            if (k == 8) req_valid = 2'b01;
        end
    endtask

    task automatic test_buffer_full();
        logic [18:0] obs, exp;
        do_reset();
        req_valid = 2'b01; write_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 0)                exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, 1'b0, 0);
            else if (k <= 4)           exp = pk2(1, 5'(k-1), {4'd1, 4'(k-1)}, 2'b01, 0, 1'b0, 1);
            else if (k <= 8)           exp = pk2(1, 5'd4, 8'h14, 2'b00, 0, 1'b0, 1);
            else if (k <= 19)          exp = pk2(1, 5'(k-5), {4'd1, 4'(k-5)}, 2'b01, 0, 1'b0, 1);
            else if (k <= 21)          exp = pk2(1, 5'd15, 8'h1F, 2'b00, 0, 1'b0, 1);
            else if (k == 22)          exp = pk2(1, 5'd15, 8'h1F, 2'b01, 0, 1'b0, 1);
            else                       exp = pk2(0, 5'd0, 8'h00, 2'b00, 1, 1'b0, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL buffer_full k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 23) begin
                vectors++;
                if (wcount !== 16) begin
                    miscompares++;
                    $display("FAIL buffer_full_count got %0d want 16", wcount);
                end
            end
            @(posedge clk); #1;
            if (k == 4 || k == 19) write_ready = 1'b0;
            if (k == 8 || k == 21) write_ready = 1'b1;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [18:0] obs, exp;
        int adv0;
        do_reset();
        adv0 = adv_count;
        req_valid = 2'b10; write_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, 1'b0, 0);
            else        exp = pk2(1, 5'(k-1), {4'd2, 4'(k-1)}, 2'b10, 0, 1'b1, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid k=%0d got %h want %h", k, obs, exp);
            end
            if (k < 10) begin
                @(posedge clk); #1;
            end
        end
        // Assert reset between clock edges: outputs must clear without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async got %h want %h", obs, 19'd0);
        end
        req_valid = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) exp = pk2(0, 5'd0, 8'h00, 2'b00, 0, 1'b0, 0);
            else        exp = pk2(1, 5'd0, 8'h10, 2'b01, 0, 1'b0, 1);
            obs = pk2(write_valid, write_addr, write_data, req_ready, write_advance, grant_idx, busy);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_regrant k=%0d got %h want %h", k, obs, exp);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (adv_count !== adv0) begin
            miscompares++;
            $display("FAIL reset_mid_no_advance got %0d want %0d", adv_count, adv0);
        end
    endtask

    task automatic test_three_way();
        logic [20:0] obs, exp;
        int w, p;
        logic [1:0] o, g;
        do_reset();
        req_valid3 = 3'b111; write_ready3 = 1'b1;
        for (int k = 0; k < 108; k++) begin
            @(negedge clk);
            w = k / 18; p = k % 18;
            o = 2'(w % 3);
            g = (w == 0) ? 2'd0 : 2'((w - 1) % 3);
            if (p == 0)       exp = pk3(0, 5'd0, 8'h00, 3'b000, 0, g, 0);
            else if (p == 17) exp = pk3(0, 5'd0, 8'h00, 3'b000, 1, o, 1);
            else              exp = pk3(1, 5'(p-1), {4'(o+1), 4'(p-1)}, 3'(1 << o), 0, o, 1);
            obs = pk3(write_valid3, write_addr3, write_data3, req_ready3, write_advance3, grant_idx3, busy3);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL three_way k=%0d got %h want %h", k, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_valid3 = '0; write_ready = 1'b0; write_ready3 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_owner_drop();
        test_buffer_full();
        test_reset_mid_burst();
        test_three_way();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
